// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C master sequencer driving the I2C datapath controls
//   clk, resetN (async, active-high)          system clock and reset
//   start, rw_in, sda_in                      host request, direction, bus SDA for ACK sampling
//   i2c_scl_in, i2c_scl_en, i2c_write_en      divided SCL, force-SCL-high, master drives SDA
//   state[7:0], count[3:0], rw                datapath state code, bit index, latched direction
//   busy, done, nack                          host handshake and NACK status
module i2c_master_ctrl #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       start,
   input  logic       rw_in,
   input  logic       sda_in,
   output logic       i2c_scl_in,
   output logic       i2c_scl_en,
   output logic       i2c_write_en,
   output logic [7:0] state,
   output logic [3:0] count,
   output logic       rw,
   output logic       busy,
   output logic       done,
   output logic       nack
);
   localparam int DW = $clog2(CLK_DIV);
   typedef enum logic [7:0] {
      S_IDLE = 8'd0, S_START = 8'd1, S_ADDRESS = 8'd2, S_READ_ACK = 8'd3, S_WRITE_DATA = 8'd4,
      S_READ_ACK2 = 8'd5, S_READ_DATA = 8'd6, S_WRITE_ACK2 = 8'd7, S_STOP = 8'd8
   } state_t;
   state_t        state_q, state_d;
   logic [3:0]    count_q, count_d;
   logic [DW-1:0] div_q, div_d;
   logic          scl_q, scl_d, scl_en_q, we_q;
   logic          rw_q, rw_d, busy_q, busy_d, done_q, done_d, nack_q, nack_d, ack_q, ack_d;
   logic          wrap, fall_tick, rise_tick, last;
   always_comb begin
      wrap      = busy_q && div_q == DW'(CLK_DIV - 1);
      fall_tick = wrap && scl_q;
      rise_tick = wrap && !scl_q;
      last      = count_q == 4'd0;
      div_d     = (wrap || !busy_q) ? '0 : div_q + 1'b1;
      scl_d     = busy_q ? scl_q ^ wrap : 1'b1;
      ack_d     = (rise_tick && (state_q == S_READ_ACK || state_q == S_READ_ACK2)) ? sda_in : ack_q;
      state_d   = state_q;
      count_d   = count_q;
      rw_d      = rw_q;
      busy_d    = busy_q;
      nack_d    = nack_q;
      done_d    = 1'b0;
      if (state_q == S_IDLE) begin
         // The accept edge counts as the first SCL fall so START spans a full SCL period.
         if (start && !done_q) begin
            state_d = S_START;
            busy_d  = 1'b1;
            rw_d    = rw_in;
            nack_d  = 1'b0;
            scl_d   = 1'b0;
         end
      end else if (fall_tick) begin
         unique case (state_q)
            S_START: state_d = S_ADDRESS;
            S_ADDRESS: begin
               state_d = last ? S_READ_ACK : S_ADDRESS;
               count_d = last ? 4'd7 : count_q - 4'd1;
            end
            S_READ_ACK: begin
               state_d = ack_q ? S_STOP : (rw_q ? S_READ_DATA : S_WRITE_DATA);
               nack_d  = ack_q;
            end
            S_WRITE_DATA: begin
               state_d = last ? S_READ_ACK2 : S_WRITE_DATA;
               count_d = last ? 4'd7 : count_q - 4'd1;
            end
            S_READ_ACK2: begin
               state_d = S_STOP;
               nack_d  = nack_q | ack_q;
            end
            S_READ_DATA: begin
               state_d = last ? S_WRITE_ACK2 : S_READ_DATA;
               count_d = last ? 4'd7 : count_q - 4'd1;
            end
            S_WRITE_ACK2: state_d = S_STOP;
            S_STOP: begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               scl_d   = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge resetN) begin
      if (resetN) begin
         state_q  <= S_IDLE;
         count_q  <= 4'd7;
         div_q    <= '0;
         scl_q    <= 1'b1;
         scl_en_q <= 1'b1;
         we_q     <= 1'b0;
         rw_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         nack_q   <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         div_q    <= div_d;
         scl_q    <= scl_d;
         scl_en_q <= state_d inside {S_IDLE, S_START, S_STOP};
         we_q     <= state_d inside {S_START, S_ADDRESS, S_WRITE_DATA, S_WRITE_ACK2, S_STOP};
         rw_q     <= rw_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         nack_q   <= nack_d;
         ack_q    <= ack_d;
      end
   end
   assign i2c_scl_in   = scl_q;
   assign i2c_scl_en   = scl_en_q;
   assign i2c_write_en = we_q;
   assign state        = state_q;
   assign count        = count_q;
   assign rw           = rw_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign nack         = nack_q;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: scoreboard bench for i2c_master_ctrl (CLK_DIV=4 main instance, CLK_DIV=2 timing instance)
module tb_i2c_master_ctrl;
   logic clk = 1'b0, resetN = 1'b1;
   logic start = 1'b0, rw_in = 1'b0, sda_a = 1'b0, sda_b = 1'b0, sda_in;
   logic scl, scl_en, we, rw, busy, done, nack;
   logic [7:0] st;
   logic [3:0] cnt;
   logic start2 = 1'b0, rw2 = 1'b1, sda2 = 1'b0;
   logic scl2, scl_en2, we2, rwo2, busy2, done2, nack2;
   logic [7:0] st2;
   logic [3:0] cnt2;
   // slave model: address ACK/NACK from sda_a, data ACK/NACK from sda_b
   assign sda_in = (st == 8'd5) ? sda_b : sda_a;
   i2c_master_ctrl #(.CLK_DIV(4)) dut (
      .clk(clk), .resetN(resetN), .start(start), .rw_in(rw_in), .sda_in(sda_in),
      .i2c_scl_in(scl), .i2c_scl_en(scl_en), .i2c_write_en(we), .state(st), .count(cnt),
      .rw(rw), .busy(busy), .done(done), .nack(nack));
   i2c_master_ctrl #(.CLK_DIV(2)) dut2 (
      .clk(clk), .resetN(resetN), .start(start2), .rw_in(rw2), .sda_in(sda2),
      .i2c_scl_in(scl2), .i2c_scl_en(scl_en2), .i2c_write_en(we2), .state(st2), .count(cnt2),
      .rw(rwo2), .busy(busy2), .done(done2), .nack(nack2));
   always #5 clk = ~clk;
   typedef struct packed {
      logic [31:0] seq;
      logic [31:0] addr;
      logic [31:0] lat;
      logic        nack;
   } exp_t;
   exp_t sbq[$];
   int total = 0, bad = 0, cyc = 0, accepts = 0;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic check_reset(string name);
      chk(name, {19'd0, st, cnt, scl, scl_en, we, rw, busy, done, nack},
          {19'd0, 8'd0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
   endtask
   // monitor: rebuilds the compressed state trace and address-count trace, scores on done
   initial begin
      logic pbusy;
      logic [7:0] pst;
      logic [3:0] pcnt;
      logic [31:0] seq, addr;
      int t0, lat;
      exp_t e;
      pbusy = 1'b0; pst = 8'd0; pcnt = 4'd7; seq = 0; addr = 0; t0 = 0;
      forever begin
         @(negedge clk);
         if (resetN) begin
            pbusy = 1'b0;
            pst = 8'd0;
            pcnt = 4'd7;
         end else begin
            if (busy && !pbusy) begin
               accepts++;
               seq = {24'd0, st};
               addr = 0;
               t0 = cyc;
            end else if (st != pst) seq = {seq[27:0], st[3:0]};
            if (st == 8'd2 && (st != pst || cnt != pcnt)) addr = {addr[27:0], cnt};
            chk("scl_en", {31'd0, scl_en}, {31'd0, st == 8'd0 || st == 8'd1 || st == 8'd8});
            chk("write_en", {31'd0, we}, {31'd0, st inside {8'd1, 8'd2, 8'd4, 8'd7, 8'd8}});
            if (!(st inside {8'd2, 8'd4, 8'd6})) chk("count_hold", {28'd0, cnt}, 32'd7);
            if (!busy) chk("scl_idle", {31'd0, scl}, 32'd1);
            if (pbusy && !busy) chk("busy_drop_only_at_done", {31'd0, done}, 32'd1);
            if (done) begin
               if (sbq.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_done: got done=1 required no done");
               end else begin
                  e = sbq.pop_front();
                  lat = cyc - t0;
                  chk("state_seq", seq, e.seq);
                  chk("addr_count_seq", addr, e.addr);
                  chk("nack", {31'd0, nack}, {31'd0, e.nack});
                  total++;
                  if (lat < int'(e.lat) - 1 || lat > int'(e.lat) + 1) begin
                     bad++;
                     $display("FAIL latency: got %0d clk required %0d+-1", lat, e.lat);
                  end
               end
            end
            pbusy = busy;
            pst = st;
            pcnt = cnt;
         end
      end
   end
   task automatic wait_idle();
      for (int i = 0; i < 3000 && (busy || done || st != 8'd0); i++) @(negedge clk);
   endtask
   task automatic wait_done(string name);
      int n = 0;
      while (!done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL %s: got no done within 2000 clk required done", name);
      end
   endtask
   task automatic go(string name, logic r, logic a, logic b, exp_t e);
      wait_idle();
      rw_in = r;
      sda_a = a;
      sda_b = b;
      start = 1'b1;
      sbq.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk({name, "_accept_busy"}, {31'd0, busy}, 32'd1);
      chk({name, "_accept_nack_clr"}, {31'd0, nack}, 32'd0);
      chk({name, "_accept_rw"}, {31'd0, rw}, {31'd0, r});
      wait_done(name);
      @(negedge clk);
      chk({name, "_nack_held"}, {31'd0, nack}, {31'd0, e.nack});
   endtask
   localparam exp_t WR  = '{seq: 32'h1234580, addr: 32'h76543210, lat: 32'd160, nack: 1'b0};
   localparam exp_t RD  = '{seq: 32'h1236780, addr: 32'h76543210, lat: 32'd160, nack: 1'b0};
   localparam exp_t ANK = '{seq: 32'h12380,   addr: 32'h76543210, lat: 32'd88,  nack: 1'b1};
   localparam exp_t DNK = '{seq: 32'h1234580, addr: 32'h76543210, lat: 32'd160, nack: 1'b1};
   initial begin
      int a0, t0, last_t, n;
      logic pscl, found;
      logic [7:0] pst2;
      logic [3:0] pcnt2;
      logic [31:0] atr, dtr;
      repeat (3) @(negedge clk);
      check_reset("reset_values");
      resetN = 1'b0;
      @(negedge clk);
      // asynchronous reset in the middle of ADDRESS
      start = 1'b1;
      rw_in = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 200 && st != 8'd2; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 resetN = 1'b1;
      #1 check_reset("mid_address_reset");
      repeat (2) @(negedge clk);
      resetN = 1'b0;
      repeat (200) @(negedge clk);
      chk("after_abort_idle", {24'd0, st}, 32'd0);
      go("write_ack", 1'b0, 1'b0, 1'b0, WR);
      go("read_ack", 1'b1, 1'b0, 1'b0, RD);
      go("addr_nack", 1'b0, 1'b1, 1'b0, ANK);
      go("write_after_nack", 1'b0, 1'b0, 1'b0, WR);
      go("data_nack", 1'b0, 1'b0, 1'b1, DNK);
      go("read_after_nack", 1'b1, 1'b0, 1'b0, RD);
      // start held high across two transfers
      wait_idle();
      a0 = accepts;
      rw_in = 1'b0;
      sda_a = 1'b0;
      sda_b = 1'b0;
      sbq.push_back(WR);
      sbq.push_back(WR);
      start = 1'b1;
      @(negedge clk);
      wait_done("held_first");
      @(negedge clk);
      chk("start_at_done_ignored", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("reaccept_next_clk", {31'd0, busy}, 32'd1);
      wait_done("held_second");
      start = 1'b0;
      repeat (20) @(negedge clk);
      chk("one_accept_per_idle", accepts - a0, 32'd2);
      chk("held_end_idle", {31'd0, busy}, 32'd0);
      // CLK_DIV=2 instance: SCL half-period and count sequences
      pscl = scl2;
      pst2 = st2;
      pcnt2 = cnt2;
      atr = 0;
      dtr = 0;
      last_t = -1;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      t0 = cyc;
      found = 1'b0;
      n = 0;
      while (!found && n < 500) begin
         if (scl2 != pscl) begin
            if (last_t >= 0) chk("div2_half_period", cyc - last_t, 32'd2);
            last_t = cyc;
         end
         if ((st2 == 8'd2 || st2 == 8'd6) && (st2 != pst2 || cnt2 != pcnt2))
            if (st2 == 8'd2) atr = {atr[27:0], cnt2};
            else dtr = {dtr[27:0], cnt2};
         pscl = scl2;
         pst2 = st2;
         pcnt2 = cnt2;
         found = done2;
         if (!found) begin
            @(negedge clk);
            n++;
         end
      end
      total++;
      if (!found || cyc - t0 < 79 || cyc - t0 > 81) begin
         bad++;
         $display("FAIL div2_latency: got %0d clk (done=%0b) required 80+-1", cyc - t0, found);
      end
      chk("div2_addr_counts", atr, 32'h76543210);
      chk("div2_data_counts", dtr, 32'h76543210);
      chk("div2_nack", {31'd0, nack2}, 32'd0);
      repeat (5) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #1000000;
      $display("FAIL global_timeout: got no finish required finish");
      $fatal(1, "timeout");
   end
endmodule
